// File: rtl/uart_xfer_mem.sv
// ----------------------------------------------------------------------------
// uart_xfer_mem
//
// Full-duplex UART transceiver feeding a word-addressed capture memory.
// TX serialises DATA_W-bit words (LSB first) on request; RX deserialises
// incoming frames and presents each received word on a one-cycle write
// port (we/address/data_out).  The write address auto-increments after
// every write and wraps modulo 2^ADDR_W.
//
// Optional feature macro: UART_XFER_PARITY_EN
//   When defined, TX appends an even-parity bit after the data bits.  RX
//   checks it and reports mismatches on the sticky parity_err output.
//   When undefined there is no parity bit, no PARITY state and no
//   parity_err port.
//
// Parameters:
//   DATA_W        data bits per frame (5..9)
//   CLKS_PER_BIT  clk cycles per serial bit (>= 4)
//   STOP_BITS     stop bits per TX frame (1 or 2); RX checks only the first
//   ADDR_W        write address width
//   BASE_ADDR     first write address after reset or addr_clr
//
// Ports:
//   clk           rising-edge clock
//   reset_n       asynchronous active-low reset
//   en            TX start request, accepted only while tx_busy = 0
//   data_in       TX word, captured when en is accepted
//   tx            serial output, idle high
//   tx_busy       high from the cycle after acceptance to the end of stop
//   rx            serial input (asynchronous, synchronised internally)
//   data_out      last received word
//   we            one-cycle memory write strobe
//   address       write address belonging to data_out while we = 1
//   done          one-cycle pulse, identical to we
//   frame_err     sticky: a stop bit was sampled low
//   parity_err    sticky: received parity mismatch (parity build only)
//   addr_clr      synchronous: address <- BASE_ADDR, error flags cleared
//   tx_state_dbg  current TX FSM state
//   rx_state_dbg  current RX FSM state
//
// TX handshake: en acts as "valid" and ~tx_busy as "ready".  A word is
// transferred on a rising edge where en = 1 and tx_busy = 0; data_in must
// be stable in that cycle.  en while tx_busy = 1 is ignored, nothing is
// queued.  Holding en high sends frames back to back, one idle cycle apart.
// ----------------------------------------------------------------------------
module uart_xfer_mem #(
    parameter int                DATA_W       = 8,
    parameter int                CLKS_PER_BIT = 16,
    parameter int                STOP_BITS    = 1,
    parameter int                ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR    = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en,
    input  logic [DATA_W-1:0] data_in,
    output logic              tx,
    output logic              tx_busy,
    input  logic              rx,
    output logic [DATA_W-1:0] data_out,
    output logic              we,
    output logic [ADDR_W-1:0] address,
    output logic              done,
    output logic              frame_err,
`ifdef UART_XFER_PARITY_EN
    output logic              parity_err,
`endif
    input  logic              addr_clr,
    output logic [2:0]        tx_state_dbg,
    output logic [2:0]        rx_state_dbg
);

    // ------------------------------------------------------------------
    // State encodings (shared numbering for TX and RX)
    // ------------------------------------------------------------------
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
`ifdef UART_XFER_PARITY_EN
    localparam logic [2:0] ST_PARITY = 3'd3;
`endif
    localparam logic [2:0] ST_STOP   = 3'd4;
    localparam logic [2:0] ST_WRITE  = 3'd5;

    // The baud counter must reach the longest TX state: STOP with two bits.
    localparam int CNT_W = $clog2(STOP_BITS * CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_W);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS * CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] IDX_LAST  = BIT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [BIT_W-1:0] IDX_ONE   = BIT_W'(1);

    // ------------------------------------------------------------------
    // TX path
    // ------------------------------------------------------------------
    logic [2:0]        tx_state;
    logic [CNT_W-1:0]  tx_cnt;
    logic [BIT_W-1:0]  tx_idx;
    logic [DATA_W-1:0] tx_shift;
    logic              tx_q;
`ifdef UART_XFER_PARITY_EN
    logic              tx_par;
`endif

    // tx is a flop so the pin never glitches; the reset value puts the
    // line high the moment reset_n falls.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_state <= ST_IDLE;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_shift <= '0;
            tx_q     <= 1'b1;
`ifdef UART_XFER_PARITY_EN
            tx_par   <= 1'b0;
`endif
        end else begin
            case (tx_state)
                ST_IDLE: begin
                    tx_q   <= 1'b1;
                    tx_cnt <= '0;
                    tx_idx <= '0;
                    if (en) begin
                        tx_shift <= data_in;
`ifdef UART_XFER_PARITY_EN
                        tx_par   <= ^data_in;
`endif
                        tx_q     <= 1'b0;
                        tx_state <= ST_START;
                    end
                end
                ST_START: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt   <= '0;
                        tx_idx   <= '0;
                        tx_q     <= tx_shift[0];
                        tx_state <= ST_DATA;
                    end else begin
                        tx_cnt <= tx_cnt + CNT_ONE;
                    end
                end
                ST_DATA: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt   <= '0;
                        tx_shift <= tx_shift >> 1;
                        if (tx_idx == IDX_LAST) begin
`ifdef UART_XFER_PARITY_EN
                            tx_q     <= tx_par;
                            tx_state <= ST_PARITY;
`else
                            tx_q     <= 1'b1;
                            tx_state <= ST_STOP;
`endif
                        end else begin
                            tx_idx <= tx_idx + IDX_ONE;
                            // Next bit is the one about to become bit 0.
                            tx_q   <= tx_shift[1];
                        end
                    end else begin
                        tx_cnt <= tx_cnt + CNT_ONE;
                    end
                end
`ifdef UART_XFER_PARITY_EN
                ST_PARITY: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt   <= '0;
                        tx_q     <= 1'b1;
                        tx_state <= ST_STOP;
                    end else begin
                        tx_cnt <= tx_cnt + CNT_ONE;
                    end
                end
`endif
                ST_STOP: begin
                    tx_q <= 1'b1;
                    if (tx_cnt == STOP_LAST) begin
                        tx_cnt   <= '0;
                        tx_state <= ST_IDLE;
                    end else begin
                        tx_cnt <= tx_cnt + CNT_ONE;
                    end
                end
                default: begin
                    tx_q     <= 1'b1;
                    tx_cnt   <= '0;
                    tx_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx           = tx_q;
    assign tx_busy      = (tx_state != ST_IDLE);
    assign tx_state_dbg = tx_state;

    // ------------------------------------------------------------------
    // RX input synchroniser and start-edge detector
    // ------------------------------------------------------------------
    logic rx_meta;
    logic rx_sync;
    logic rx_prev;
    logic rx_fall;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // Edge rather than level: after a low stop bit the line may still be
    // low when RX is back in IDLE, and that must not start a new frame.
    assign rx_fall = rx_prev & ~rx_sync;

    // ------------------------------------------------------------------
    // RX FSM, write port and sticky error flags
    // ------------------------------------------------------------------
    logic [2:0]        rx_state;
    logic [CNT_W-1:0]  rx_cnt;
    logic [BIT_W-1:0]  rx_idx;
    logic [DATA_W-1:0] rx_shift;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_state   <= ST_IDLE;
            rx_cnt     <= '0;
            rx_idx     <= '0;
            rx_shift   <= '0;
            data_out   <= '0;
            address    <= BASE_ADDR;
            frame_err  <= 1'b0;
`ifdef UART_XFER_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            // Clear first so an error detected in the same cycle still sets.
            if (addr_clr) begin
                frame_err  <= 1'b0;
`ifdef UART_XFER_PARITY_EN
                parity_err <= 1'b0;
`endif
            end

            case (rx_state)
                ST_IDLE: begin
                    rx_cnt <= '0;
                    rx_idx <= '0;
                    if (rx_fall) begin
                        rx_state <= ST_START;
                    end
                end
                ST_START: begin
                    // Re-check the start bit half a bit in; from here on the
                    // counter is aligned to mid-bit sample points.
                    if (rx_cnt == HALF_LAST) begin
                        rx_cnt   <= '0;
                        rx_state <= rx_sync ? ST_IDLE : ST_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + CNT_ONE;
                    end
                end
                ST_DATA: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_sync, rx_shift[DATA_W-1:1]};
                        if (rx_idx == IDX_LAST) begin
`ifdef UART_XFER_PARITY_EN
                            rx_state <= ST_PARITY;
`else
                            rx_state <= ST_STOP;
`endif
                        end else begin
                            rx_idx <= rx_idx + IDX_ONE;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + CNT_ONE;
                    end
                end
`ifdef UART_XFER_PARITY_EN
                ST_PARITY: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt <= '0;
                        if (rx_sync != (^rx_shift)) begin
                            parity_err <= 1'b1;
                        end
                        rx_state <= ST_STOP;
                    end else begin
                        rx_cnt <= rx_cnt + CNT_ONE;
                    end
                end
`endif
                ST_STOP: begin
                    // Only the first stop bit is sampled; the word is kept
                    // even when the stop bit is bad.
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt <= '0;
                        if (!rx_sync) begin
                            frame_err <= 1'b1;
                        end
                        data_out <= rx_shift;
                        rx_state <= ST_WRITE;
                    end else begin
                        rx_cnt <= rx_cnt + CNT_ONE;
                    end
                end
                ST_WRITE: begin
                    // Back to IDLE mid stop bit, ready half a bit early.
                    address  <= address + ADDR_W'(1);
                    rx_state <= ST_IDLE;
                end
                default: begin
                    rx_cnt   <= '0;
                    rx_state <= ST_IDLE;
                end
            endcase

            // A clear overrides the post-write increment.
            if (addr_clr) begin
                address <= BASE_ADDR;
            end
        end
    end

    assign we           = (rx_state == ST_WRITE);
    assign done         = we;
    assign rx_state_dbg = rx_state;

endmodule

// File: tb/tb_uart_xfer_mem.sv
// ----------------------------------------------------------------------------
// tb_uart_xfer_mem
//
// Bench for uart_xfer_mem (DATA_W=8, CLKS_PER_BIT=16, STOP_BITS=1).
// The reference model describes each TX frame as a list of line levels, one
// per clock, and each expected memory write as a queue entry; the address
// model is a plain counter.  A single negedge process compares the DUT
// against that model every cycle.  Define UART_XFER_PARITY_EN for the
// parity build.
// ----------------------------------------------------------------------------
module tb_uart_xfer_mem;

  localparam int DATA_W    = 8;
  localparam int CPB       = 16;
  localparam int STOP_BITS = 1;
  localparam int ADDR_W    = 32;
  localparam logic [ADDR_W-1:0] BASE = 32'h0000_0000;
`ifdef UART_XFER_PARITY_EN
  localparam int PAR_BITS  = 1;
  localparam int FRAME_LIT = 176;
`else
  localparam int PAR_BITS  = 0;
  localparam int FRAME_LIT = 160;
`endif
  localparam int FRAME = (1 + DATA_W + PAR_BITS + STOP_BITS) * CPB;
  // exp_q entry: {parity error expected, frame error expected, data}
  localparam int W = DATA_W + 2;

  logic              clk;
  logic              reset_n;
  logic              en;
  logic [DATA_W-1:0] data_in;
  logic              tx;
  logic              tx_busy;
  logic              rx;
  logic              rx_drv;
  logic [DATA_W-1:0] data_out;
  logic              we;
  logic [ADDR_W-1:0] address;
  logic              done;
  logic              frame_err;
  logic              addr_clr;
  logic [2:0]        tx_state_dbg;
  logic [2:0]        rx_state_dbg;
`ifdef UART_XFER_PARITY_EN
  logic              parity_err;
`endif

  bit loop_mode;
  assign rx = loop_mode ? tx : rx_drv;

  int checks = 0;
  int errors = 0;

  bit                tx_exp_q[$];
  logic [W-1:0]      exp_q[$];
  logic [ADDR_W-1:0] m_addr;
  logic              m_ferr;
  logic              m_perr;
  int                wr_count;

  uart_xfer_mem #(
    .DATA_W      (DATA_W),
    .CLKS_PER_BIT(CPB),
    .STOP_BITS   (STOP_BITS),
    .ADDR_W      (ADDR_W),
    .BASE_ADDR   (BASE)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .en          (en),
    .data_in     (data_in),
    .tx          (tx),
    .tx_busy     (tx_busy),
    .rx          (rx),
    .data_out    (data_out),
    .we          (we),
    .address     (address),
    .done        (done),
    .frame_err   (frame_err),
`ifdef UART_XFER_PARITY_EN
    .parity_err  (parity_err),
`endif
    .addr_clr    (addr_clr),
    .tx_state_dbg(tx_state_dbg),
    .rx_state_dbg(rx_state_dbg)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Line levels of one TX frame, one entry per clock.
  task automatic push_tx_frame(input logic [DATA_W-1:0] d);
    repeat (CPB) tx_exp_q.push_back(1'b0);
    for (int i = 0; i < DATA_W; i++) repeat (CPB) tx_exp_q.push_back(d[i]);
`ifdef UART_XFER_PARITY_EN
    repeat (CPB) tx_exp_q.push_back(^d);
`endif
    repeat (STOP_BITS * CPB) tx_exp_q.push_back(1'b1);
  endtask

  // ---------------- scoreboard / compare process ----------------
  always @(negedge clk) begin : mon
    logic [W-1:0] e;
    bit           b;
    if (!reset_n) begin
      tx_exp_q.delete();
      exp_q.delete();
      m_addr = BASE;
      m_ferr = 1'b0;
      m_perr = 1'b0;
      check("rst_tx", tx, 1'b1);
      check("rst_tx_busy", tx_busy, 1'b0);
      check("rst_we", we, 1'b0);
    end else begin
      if (tx_exp_q.size() == 0) begin
        check("tx_idle_level", tx, 1'b1);
        check("tx_busy_idle", tx_busy, 1'b0);
        if (en === 1'b1) begin
          push_tx_frame(data_in);
          if (loop_mode) exp_q.push_back({2'b00, data_in});
        end
      end else begin
        b = tx_exp_q.pop_front();
        check("tx_bit", tx, b);
        check("tx_busy_frame", tx_busy, 1'b1);
      end

      check("done_eq_we", done, we);
      if (we === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_we", we, 1'b0);
        end else begin
          e = exp_q.pop_front();
          if (e[DATA_W])   m_ferr = 1'b1;
          if (e[DATA_W+1]) m_perr = 1'b1;
          check("wr_data", data_out, e[DATA_W-1:0]);
          check("wr_addr", address, m_addr);
          check("wr_frame_err", frame_err, m_ferr);
`ifdef UART_XFER_PARITY_EN
          check("wr_parity_err", parity_err, m_perr);
`endif
          m_addr = m_addr + 1'b1;
          wr_count++;
        end
      end
      if (addr_clr === 1'b1) begin
        m_addr = BASE;
        m_ferr = 1'b0;
        m_perr = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_tx_idle(input int bound);
    bit ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (!tx_busy) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
    check("tx_idle_timeout", ok, 1'b1);
  endtask

  task automatic wait_drain();
    bit ok = 1'b0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      if (exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
    check("rx_drain_timeout", ok, 1'b1);
    tick(2);
  endtask

  task automatic tx_send(input logic [DATA_W-1:0] d);
    data_in = d;
    en      = 1'b1;
    tick(1);
    en      = 1'b0;
    wait_tx_idle(FRAME + 8);
  endtask

  task automatic pulse_clr();
    addr_clr = 1'b1;
    tick(1);
    addr_clr = 1'b0;
  endtask

  task automatic rx_bit(input logic b);
    rx_drv = b;
    tick(CPB);
  endtask

  task automatic rx_frame(input logic [DATA_W-1:0] d, input logic stop_ok, input logic par_flip);
    exp_q.push_back({par_flip, ~stop_ok, d});
    rx_bit(1'b0);
    for (int i = 0; i < DATA_W; i++) rx_bit(d[i]);
`ifdef UART_XFER_PARITY_EN
    rx_bit((^d) ^ par_flip);
`endif
    rx_bit(stop_ok);
    rx_bit(1'b1);
    rx_bit(1'b1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lo_run;
    int busy_cnt;
    int saved;
    bit in_start;
    logic [DATA_W-1:0] d;

    reset_n   = 1'b0;
    en        = 1'b0;
    data_in   = '0;
    rx_drv    = 1'b1;
    addr_clr  = 1'b0;
    loop_mode = 1'b1;
    wr_count  = 0;
    m_addr    = BASE;
    m_ferr    = 1'b0;
    m_perr    = 1'b0;
    tick(3);

    check("reset_tx", tx, 1'b1);
    check("reset_tx_busy", tx_busy, 1'b0);
    check("reset_data_out", data_out, 8'h00);
    check("reset_we", we, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_address", address, 32'h0000_0000);
    check("reset_frame_err", frame_err, 1'b0);
    reset_n = 1'b1;
    tick(2);

    // Loopback A5: start bit width, frame length, first write.
    data_in  = 8'hA5;
    en       = 1'b1;
    tick(1);
    en       = 1'b0;
    lo_run   = 0;
    busy_cnt = 0;
    in_start = 1'b1;
    for (int i = 0; i < FRAME + 20; i++) begin
      if (!tx_busy) break;
      busy_cnt++;
      if (in_start && tx == 1'b0) lo_run++;
      else in_start = 1'b0;
      tick(1);
    end
    check("a5_start_len", lo_run, 16);
    check("a5_frame_len", busy_cnt, FRAME_LIT);
    wait_drain();
    check("a5_data_out", data_out, 8'hA5);
    check("a5_addr_after", address, 32'h0000_0001);
    check("a5_write_count", wr_count, 1);

    // Back-to-back sweep with en held high.
    pulse_clr();
    for (int k = 0; k < 256; k++) begin
      wait_tx_idle(FRAME + 8);
      data_in = DATA_W'(k);
      en      = 1'b1;
      tick(1);
    end
    en = 1'b0;
    wait_tx_idle(FRAME + 8);
    wait_drain();
    check("sweep_addr_end", address, 32'h0000_0100);
    check("sweep_last_data", data_out, 8'hFF);
    check("sweep_frame_err", frame_err, 1'b0);
    check("sweep_write_count", wr_count, 257);

    // Random loopback frames with random gaps.
    repeat (10) begin
      tx_send(DATA_W'($urandom_range(0, 255)));
      tick($urandom_range(1, 20));
    end
    wait_drain();

    // Directly driven line: glitch, then a valid frame.
    loop_mode = 1'b0;
    tick(2);
    saved  = wr_count;
    rx_drv = 1'b0;
    tick(4);
    rx_drv = 1'b1;
    tick(3 * CPB);
    check("glitch_rx_idle", rx_state_dbg, 3'd0);
    check("glitch_no_write", wr_count, saved);
    rx_frame(8'h3C, 1'b1, 1'b0);
    wait_drain();
    check("after_glitch_data", data_out, 8'h3C);

    // Low stop bit: word written, frame_err sticky until addr_clr.
    rx_frame(8'h81, 1'b0, 1'b0);
    wait_drain();
    check("bad_stop_data", data_out, 8'h81);
    check("bad_stop_frame_err", frame_err, 1'b1);
    rx_frame(DATA_W'($urandom_range(0, 255)), 1'b1, 1'b0);
    wait_drain();
    check("frame_err_sticky", frame_err, 1'b1);
    pulse_clr();
    check("clr_address", address, 32'h0000_0000);
    check("clr_frame_err", frame_err, 1'b0);

    // Random driven frames, some with bad stop bits.
    repeat (8) begin
      d = DATA_W'($urandom_range(0, 255));
`ifdef UART_XFER_PARITY_EN
      rx_frame(d, ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0));
`else
      rx_frame(d, ($urandom_range(0, 3) != 0), 1'b0);
`endif
    end
    wait_drain();

`ifdef UART_XFER_PARITY_EN
    // Parity: good loopback 07 (parity bit 1), then a flipped parity bit.
    pulse_clr();
    loop_mode = 1'b1;
    tick(2);
    tx_send(8'h07);
    wait_drain();
    check("par_07_data", data_out, 8'h07);
    check("par_07_no_err", parity_err, 1'b0);
    loop_mode = 1'b0;
    tick(2);
    rx_frame(8'h07, 1'b1, 1'b1);
    wait_drain();
    check("par_flip_err", parity_err, 1'b1);
    pulse_clr();
    check("par_clr", parity_err, 1'b0);
`endif

    // Reset in the middle of a TX FF data phase, loopback connected.
    loop_mode = 1'b1;
    tick(2);
    saved   = wr_count;
    data_in = 8'hFF;
    en      = 1'b1;
    tick(1);
    en      = 1'b0;
    tick(CPB + 40);
    reset_n = 1'b0;
    #1;
    check("mid_reset_tx", tx, 1'b1);
    check("mid_reset_tx_busy", tx_busy, 1'b0);
    check("mid_reset_tx_state", tx_state_dbg, 3'd0);
    check("mid_reset_we", we, 1'b0);
    tick(3);
    reset_n = 1'b1;
    tick(1);
    check("post_reset_address", address, 32'h0000_0000);
    tick(2 * FRAME);
    check("post_reset_no_write", wr_count, saved);
    check("post_reset_done", done, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_xfer_mem.md
Name: uart_xfer_mem

Overview:
- Parametrised UART transceiver: one full-duplex serial channel with independent TX and RX state machines.
- Width, baud divisor, stop bits and memory base are generics.
- Each received word is written to a word-addressed buffer through a we/address/data_out port; the address auto-increments.
- Sits between the board serial pins and the on-chip capture memory; successor of the fixed 8-bit uart block.

Parameters:
DATA_W, 8, data bits per frame (5..9), LSB first
CLKS_PER_BIT, 16, clk cycles per serial bit (>=4)
STOP_BITS, 1, stop bits per TX frame (1 or 2); RX checks the first only
BASE_ADDR, 32'h0000_0000, first write address after reset/clear
ADDR_W, 32, address width

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
en  in  1  TX start request; sampled only when tx_busy=0
data_in  in  DATA_W  TX word, captured on accepted en
tx  out  1  serial output, idle high
tx_busy  out  1  high from the cycle after en is accepted to the end of the last stop bit
rx  in  1  serial input, asynchronous
data_out  out  DATA_W  last received word
we  out  1  one-cycle memory write strobe
address  out  ADDR_W  write address for data_out
done  out  1  one-cycle pulse, coincident with we
frame_err  out  1  sticky: stop bit sampled low
addr_clr  in  1  synchronous: address returns to BASE_ADDR; frame_err clears

Behaviour:
- Reset values: tx=1, tx_busy=0, data_out=0, we=0, done=0, address=BASE_ADDR, frame_err=0. Both FSMs reset to IDLE.
- The rx input passes through a 2-flop synchronizer with reset value 1.
- TX FSM (IDLE, START, DATA, PARITY, STOP):
  - en=1 in IDLE latches data_in and enters START.
  - Each state lasts CLKS_PER_BIT cycles, timed by a baud counter that resets on each state entry.
  - DATA shifts out DATA_W bits, LSB first.
  - PARITY exists only under the macro.
  - STOP holds tx=1 for STOP_BITS*CLKS_PER_BIT cycles, then returns to IDLE.
  - tx_busy drops in the IDLE cycle, so back-to-back frames are possible: en held high restarts on the next cycle.
  - en while busy is ignored; there is no queueing.
- RX FSM (IDLE, START, DATA, PARITY, STOP, WRITE):
  - A falling edge on the synchronized rx in IDLE enters START.
  - At CLKS_PER_BIT/2 the line is re-sampled. If high, it is a glitch: return to IDLE, no write.
  - All later bits are sampled at mid-bit, every CLKS_PER_BIT cycles.
  - STOP: if the sample is low, set frame_err; the word is still written.
  - WRITE, one cycle: data_out updates and we=done=1 with address equal to the write target.
  - address increments on the following edge, wrapping modulo 2^ADDR_W.
  - The FSM returns to IDLE and is ready for the next start edge half a bit early, which tolerates clock skew.
- addr_clr and a WRITE in the same cycle: the write completes at the current address, then address = BASE_ADDR (clear wins over increment).
- reset_n asserted mid-frame: both FSMs abort immediately, tx goes high at once, and no partial write occurs.
- TX and RX are fully independent. Loopback (rx tied to tx) must work.

Optional Feature:
- Macro UART_XFER_PARITY_EN.
- Defined:
  - TX inserts an even-parity bit (XOR of data) after DATA.
  - RX samples the parity bit.
  - Port parity_err (out, 1, sticky, cleared by addr_clr and reset) sets on mismatch; the word is still written.
- Undefined: no PARITY states, no parity_err port, and frame length is 1+DATA_W+stop bits.

Test Plan:
- Reset then loopback, DATA_W=8, CLKS_PER_BIT=16: en pulse with data_in=8'hA5 -> tx low for 16 cycles; done/we pulse once with data_out=8'hA5, address=0; address=1 afterwards; frame length 160 cycles.
- Sweep data_in 8'h00..8'hFF back-to-back in loopback with en held high -> 256 writes; address = BASE_ADDR+k for word k; data_out=k; no frame_err.
- rx glitch low for 4 cycles -> no we, RX back in IDLE; a following valid 8'h3C frame is captured correctly.
- Driven frame 8'h81 with a low stop bit -> we with data_out=8'h81, frame_err=1 stays set until addr_clr; addr_clr then gives address=BASE_ADDR.
- reset_n low mid-DATA of TX 8'hFF -> tx=1 and tx_busy=0 immediately; after release address=BASE_ADDR, no spurious done.
- With UART_XFER_PARITY_EN, loopback 8'h07 -> parity bit 1 on tx; injecting a flipped parity bit -> parity_err=1.
